// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline stages.
//   WORD_W         : datapath word width
//   RESET_PC_DEF   : default program counter after reset
//   NOP_INSTR_DEF  : default bubble instruction (sll $0,$0,0)
//   fetch_state_t  : fetch FSM states
//   if_id_t        : IF/ID pipeline register contents
package pipeline_pkg;

  localparam int WORD_W = 32;

  localparam logic [WORD_W-1:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [WORD_W-1:0] NOP_INSTR_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] pc4;
    logic              valid;
  } if_id_t;

  // Instruction fetches are word aligned; the low two address bits are dropped.
  function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
    return addr & ~{{(WORD_W-2){1'b0}}, 2'b11};
  endfunction

endpackage

// File: rtl/stage_one_fetch_if_id_reg.sv
// IF/ID pipeline register, same shape as the ID/EX register downstream.
//   clk, rst_n              : clock, asynchronous active-low reset
//   flush                   : load a bubble (highest priority)
//   stall                   : hold all fields
//   load                    : capture instr_in/pc4_in/valid_in
//   instr_in/pc4_in/valid_in: next instruction word, its PC+4, valid flag
//   instr_out/pc4_out/valid_out : registered values to decode
// With none of flush/stall/load a bubble is loaded, so decode never sees
// the same word twice.
module if_id_reg
  import pipeline_pkg::*;
#(
  parameter logic [WORD_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              stall,
  input  logic              load,
  input  logic [WORD_W-1:0] instr_in,
  input  logic [WORD_W-1:0] pc4_in,
  input  logic              valid_in,
  output logic [WORD_W-1:0] instr_out,
  output logic [WORD_W-1:0] pc4_out,
  output logic              valid_out
);

  if_id_t if_id_q, if_id_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    if_id_d = if_id_q;
    if (flush) begin
      if_id_d = {NOP_INSTR, {WORD_W{1'b0}}, 1'b0};
    end else if (stall) begin
      if_id_d = if_id_q;
    end else if (load) begin
      if_id_d = {instr_in, pc4_in, valid_in};
    end else begin
      if_id_d = {NOP_INSTR, {WORD_W{1'b0}}, 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    if (!rst_n) begin
      if_id_q <= {NOP_INSTR, {WORD_W{1'b0}}, 1'b0};
    end else begin
      if_id_q <= if_id_d;
    end
  end

  assign instr_out = if_id_q.instr;
  assign pc4_out   = if_id_q.pc4;
  assign valid_out = if_id_q.valid;

endmodule

// File: rtl/stage_one_fetch.sv
// Instruction-fetch stage: owns the PC, issues one word fetch at a time to a
// variable-latency instruction memory and feeds the IF/ID register.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   stall                      : hazard unit hold of IF/ID and PC
//   branch_taken/branch_target : redirect fetch and flush IF/ID
//   imem_req/imem_addr         : fetch strobe and word address
//   imem_rvalid/imem_rdata     : returned instruction
//   if_instruction/if_pc_plus4/if_valid : IF/ID outputs to decode
module stage_one_fetch
  import pipeline_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [WORD_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [WORD_W-1:0] branch_target,
  output logic              imem_req,
  output logic [WORD_W-1:0] imem_addr,
  input  logic              imem_rvalid,
  input  logic [WORD_W-1:0] imem_rdata,
  output logic [WORD_W-1:0] if_instruction,
  output logic [WORD_W-1:0] if_pc_plus4,
  output logic              if_valid
);

  fetch_state_t      state_q, state_d;
  logic [WORD_W-1:0] pc_q, pc_d;
  logic [WORD_W-1:0] hold_q, hold_d;
  logic              kill_q, kill_d;   // response in flight belongs to a squashed fetch
  logic              run_q, run_d;     // keeps imem_req low until the first edge out of reset

  logic [WORD_W-1:0] pc_plus4;
  logic [WORD_W-1:0] target;
  logic              deliver;
  logic [WORD_W-1:0] if_instr_in;

  assign pc_plus4 = pc_q + 32'd4;      // wraps modulo 2^32
  assign target   = word_align(branch_target);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      kill_q  <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      kill_q  <= kill_d;
      run_q   <= run_d;
    end
  end

  // NOTE: hold_q is pure datapath, only read in HOLD after being written, so it
  // needs no reset.
  always_ff @(posedge clk) begin
    hold_q <= hold_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    kill_d  = kill_q;
    hold_d  = hold_q;
    run_d   = 1'b1;
    deliver = 1'b0;
    case (state_q)
      FETCH: begin
        if (run_q) begin
          // The request goes out even on a redirect; its response is squashed.
          state_d = WAIT;
          if (branch_taken) begin
            kill_d = 1'b1;
            pc_d   = target;
          end
        end else if (branch_taken) begin
          pc_d = target;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          state_d = FETCH;
          kill_d  = 1'b0;
          if (branch_taken) begin
            pc_d = target;
          end else if (!kill_q) begin
            if (stall) begin
              hold_d  = imem_rdata;
              state_d = HOLD;
            end else begin
              deliver = 1'b1;
              pc_d    = pc_plus4;
            end
          end
        end else if (branch_taken) begin
          kill_d = 1'b1;
          pc_d   = target;
        end
      end
      HOLD: begin
        if (branch_taken) begin
          pc_d    = target;
          state_d = FETCH;
        end else if (!stall) begin
          deliver = 1'b1;
          pc_d    = pc_plus4;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  // Output logic
  always_comb begin
    imem_req    = run_q && (state_q == FETCH);
    imem_addr   = pc_q;
    if_instr_in = (state_q == HOLD) ? hold_q : imem_rdata;
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (branch_taken),
    .stall     (stall),
    .load      (deliver),
    .instr_in  (if_instr_in),
    .pc4_in    (pc_plus4),
    .valid_in  (1'b1),
    .instr_out (if_instruction),
    .pc4_out   (if_pc_plus4),
    .valid_out (if_valid)
  );

endmodule

// File: doc/stage_one_fetch.md
Name: stage_one_fetch

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the decode stage.
- Owns the program counter and issues word fetches to a variable-latency instruction memory, with one request outstanding at a time.
- Captures each returned instruction and its PC+4 into the IF/ID pipeline register, which feeds the decode stage's instruction and pc inputs.
- Honours the hazard-unit stall and taken-branch redirect/flush.

Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset.
- NOP_INSTR, 32'h0000_0000, instruction word injected as a bubble (sll $0,$0,0).

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hazard unit: hold IF/ID and PC this cycle.
- branch_taken  in  1  one-cycle pulse: redirect fetch and flush IF/ID.
- branch_target  in  32  redirect address; bits [1:0] ignored (forced 0).
- imem_req  out  1  fetch request strobe; always accepted in the cycle it is asserted.
- imem_addr  out  32  fetch word address, equal to pc_q while imem_req=1.
- imem_rvalid  in  1  read data valid, at least 1 cycle after the request.
- imem_rdata  in  32  instruction word.
- if_instruction  out  32  IF/ID instruction to decode.
- if_pc_plus4  out  32  IF/ID PC+4 to decode.
- if_valid  out  1  IF/ID slot holds a real instruction (0 = bubble).

Behaviour:
- Reset (async, rst_n=0):
  - pc_q=RESET_PC, state=FETCH, kill=0.
  - if_instruction=NOP_INSTR, if_pc_plus4=0, if_valid=0, imem_req=0.
  - Reset mid-transaction discards any outstanding response.
  - The first request is issued in the first cycle after reset release.
- FSM states: FETCH, WAIT, HOLD.
- FETCH:
  - imem_req=1, imem_addr=pc_q (combinational from state/pc_q); next state WAIT.
  - If branch_taken is asserted in the same cycle, the request is still issued. kill is set, pc_q<=target, then WAIT.
- WAIT:
  - imem_req=0.
  - On imem_rvalid with kill=1: discard the data, kill<=0, go to FETCH.
  - On imem_rvalid with kill=0 and branch_taken=0:
    - stall=0: IF/ID<={rdata, pc_q+4, 1}, pc_q<=pc_q+4, go to FETCH.
    - stall=1: capture rdata into the hold register, go to HOLD.
  - On branch_taken with imem_rvalid in the same cycle: discard rdata, pc_q<=target, kill stays 0, go to FETCH.
  - On branch_taken without imem_rvalid: kill<=1, pc_q<=target, remain in WAIT.
- HOLD:
  - imem_req=0.
  - When stall=0: IF/ID<={hold, pc_q+4, 1}, pc_q<=pc_q+4, go to FETCH.
  - On branch_taken: drop the held word, pc_q<=target, go to FETCH.
- IF/ID update rules, in priority order:
  1. branch_taken: load {NOP_INSTR, 0, 0}. Flush wins over stall.
  2. stall: hold all IF/ID fields.
  3. New instruction delivered: load it.
  4. Otherwise: load a bubble {NOP_INSTR, 0, 0}, so decode never re-executes a word.
- Latency: memory latency L gives one instruction per (L+1) cycles. With L=1 that is one instruction every 2 cycles. Each instruction appears on IF/ID the edge after rvalid.
- Arithmetic: pc_q+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0. pc_q[1:0] is always 0.
- stall asserted while in FETCH or WAIT (no data yet) does not block the memory request. It only freezes IF/ID.

Decomposition:
- Shared package pipeline_pkg holds:
  - NOP_INSTR and RESET_PC defaults;
  - the fetch_state_t enum {FETCH, WAIT, HOLD};
  - the 32-bit word width constant.
- Sub-module if_id_reg holds the IF/ID pipeline register, mirroring the existing ID/EX register. Ports: clk, rst_n, flush, stall, load, instr_in, pc4_in, valid_in, and the three outputs. The fetch FSM, PC and hold register stay in stage_one_fetch.

Test Plan:
- Reset release with 1-cycle memory returning 32'h2001_0005 at address 0 -> imem_req at cycle 1 with addr 0. IF/ID shows {32'h2001_0005, 32'h4, 1} after rvalid. Next request has addr 4.
- stall=1 for 3 cycles while rvalid arrives -> FSM enters HOLD, IF/ID unchanged, no new imem_req. On stall release, IF/ID loads the held word with correct PC+4.
- branch_taken with target 32'h0000_0103 while in WAIT (3-cycle memory) -> IF/ID flushed to {0, 0, 0}. Stale rdata discarded. Next imem_addr is 32'h0000_0100.
- branch_taken coincident with rvalid and stall=1 -> flush takes priority: if_valid=0, data dropped, fetch from target.
- RESET_PC=32'hFFFF_FFFC -> first fetch at FFFF_FFFC, if_pc_plus4=0, second fetch at 0.
- rst_n asserted mid-WAIT -> outputs reset immediately (asynchronously). A late rvalid after release is ignored and the fetch restarts at RESET_PC.
